phase_row_cache: RTL and testbench
==================================

PHASE_ROW_CACHE -- requirements
Module: phase_row_cache

Interface
REQ-001 SHALL have parameter ROW_SIZE, default 1280, samples per row.
REQ-002 SHALL have parameter WIN_SIZE, default 128, samples per window; NWIN = ROW_SIZE/WIN_SIZE.
REQ-003 SHALL have parameter BEAT_SIZE, default 8, samples per input beat; BPW = WIN_SIZE/BEAT_SIZE, BPR = ROW_SIZE/BEAT_SIZE.
REQ-004 SHALL have parameter DATA_WIDTH, default 16, signed sample width.
REQ-005 SHALL have parameter READ_LATENCY, default 2, read address-to-data cycles, legal range 1..8.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port s_data, input, BEAT_SIZE*DATA_WIDTH, beat samples; sample k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port s_valid, input, 1, beat valid.
REQ-010 SHALL have port s_ready, output, 1, beat accepted when s_valid & s_ready.
REQ-011 SHALL have port s_last, input, 1, producer end-of-row marker.
REQ-012 SHALL have port rd_addr, input, $clog2(NWIN), window index from matcher.
REQ-013 SHALL have port rd_data, output, WIN_SIZE*DATA_WIDTH, window samples; sample i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-014 SHALL have port row_vld, output, 1, a complete row is readable.
REQ-015 SHALL have port row_done, input, 1, single-cycle pulse: matcher finished current row.
REQ-016 SHALL have port err_len, output, 1, single-cycle pulse: s_last position mismatch.

Function
REQ-017 Accepted beat n (wr_cnt, 0..BPR-1) SHALL be stored in window wr_cnt/BPW, slot wr_cnt%BPW, of the write bank.
REQ-018 On acceptance with wr_cnt = BPR-1, the write bank SHALL be marked full and wr_cnt SHALL wrap to 0.
REQ-019 Row completion SHALL be by count only; s_last asserted at wr_cnt != BPR-1, or deasserted at wr_cnt = BPR-1, SHALL pulse err_len the following cycle, with no other effect.
REQ-020 Writer FSM SHALL have states W_FILL (s_ready=1) and W_WAIT (s_ready=0); W_FILL->W_WAIT when the row completes and no empty bank is available; W_WAIT->W_FILL the cycle after a bank frees.
REQ-021 row_vld SHALL equal the full flag of the read bank.
REQ-022 row_done with row_vld=1 SHALL clear the read bank's full flag the next cycle; row_done with row_vld=0 SHALL be ignored.
REQ-023 rd_data SHALL present window rd_addr of the read bank exactly READ_LATENCY cycles after rd_addr is applied, fully pipelined (new address every cycle).
REQ-024 rd_addr >= NWIN SHALL return all-zero rd_data at the same latency.
REQ-025 The read bank SHALL be sampled with rd_addr; a bank switch does not alter reads in flight.
REQ-026 Reads while row_vld=0 SHALL return stored contents with no error indication.

Reset
REQ-027 While rst=1: s_ready=0, row_vld=0, err_len=0, rd_data pipeline=0, wr_cnt=0, all full flags=0, write and read bank=0, writer FSM=W_FILL.
REQ-028 s_ready SHALL be 1 the first cycle after rst deasserts.
REQ-029 Storage contents SHALL NOT be cleared; reset mid-row SHALL discard the partial row.

Configuration
REQ-030 Macro PHASE_ROW_CACHE_PINGPONG_EN defined: two banks; the writer moves to the other bank on completion if it is empty, else enters W_WAIT; the reader toggles bank on accepted row_done; completion and row_done in the same cycle SHALL both take effect with no stall cycle.
REQ-031 Macro undefined: one bank; every completion enters W_WAIT until accepted row_done; row_done and the first beat of the next row are never concurrent.

Verification
REQ-032 Stream 160 beats, sample value = global sample index, s_last on beat 159 -> row_vld=1 one cycle after beat 159; rd_addr=3 -> rd_data sample 0 = 384, sample 127 = 511, 2 cycles later; err_len never set.
REQ-033 Back-to-back rd_addr 0,9,10 -> rd_data samples 0 of 0, 1152, then all-zero on consecutive cycles.
REQ-034 s_last on beat 100 -> err_len pulse cycle after beat 100; row still completes at beat 159.
REQ-035 PINGPONG_EN: stream 2 rows, no row_done -> s_ready=0 after row 2 beat 159; row_done -> s_ready=1 next cycle; reads return row 2.
REQ-036 PINGPONG_EN undefined: after row 1, s_ready=0 until row_done; row_done with row_vld=0 -> no state change.
REQ-037 rst asserted after beat 50 -> row_vld=0, s_ready=1 after release; next 160 beats form one complete row.

Source files
------------

// File: rtl/phase_row_cache.sv
// rtl/phase_row_cache.sv - row cache between a beat stream writer and a windowed matcher reader
// Optional feature macro: PHASE_ROW_CACHE_PINGPONG_EN (two banks; one bank when undefined).
module phase_row_cache #(
  parameter int ROW_SIZE     = 1280,
  parameter int WIN_SIZE     = 128,
  parameter int BEAT_SIZE    = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 2,
  localparam int NWIN = ROW_SIZE / WIN_SIZE,
  localparam int AW   = (NWIN > 1) ? $clog2(NWIN) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [BEAT_SIZE*DATA_WIDTH-1:0] s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic                            s_last,
  input  logic [AW-1:0]                   rd_addr,
  output logic [WIN_SIZE*DATA_WIDTH-1:0]  rd_data,
  output logic                            row_vld,
  input  logic                            row_done,
  output logic                            err_len
);

  localparam int BPW    = WIN_SIZE / BEAT_SIZE;
  localparam int BPR    = ROW_SIZE / BEAT_SIZE;
  localparam int BEAT_W = BEAT_SIZE * DATA_WIDTH;
  localparam int WIN_W  = WIN_SIZE * DATA_WIDTH;
  localparam int SW     = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int CW     = (BPR > 1) ? $clog2(BPR) : 1;
`ifdef PHASE_ROW_CACHE_PINGPONG_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif

  typedef enum logic {W_FILL = 1'b0, W_WAIT = 1'b1} wstate_t;

  wstate_t            state, state_n;
  logic               wr_bank, rd_bank;
  logic [NBANK-1:0]   full;
  logic [CW-1:0]      wr_cnt;
  logic [AW-1:0]      wr_win;
  logic [SW-1:0]      wr_slot;
  logic               err_q;
  logic               accept, at_last, complete, done_acc, other_free;
  logic [WIN_W-1:0]   win_data;
  logic [WIN_W-1:0]   pipe [READ_LATENCY];

  // Storage is deliberately not reset; a reset simply drops any partial row.
  logic [BEAT_W-1:0]  mem [NBANK][NWIN][BPW];

  assign accept   = s_valid && s_ready;
  assign at_last  = (wr_cnt == CW'(BPR - 1));
  assign complete = accept && at_last;
  assign row_vld  = full[rd_bank] && !rst;
  assign done_acc = row_done && row_vld;
  assign err_len  = err_q && !rst;
  assign rd_data  = rst ? '0 : pipe[READ_LATENCY-1];

`ifdef PHASE_ROW_CACHE_PINGPONG_EN
  // A bank freed by row_done in the same cycle counts as empty, so no stall cycle.
  assign other_free = !full[!wr_bank] || (done_acc && (rd_bank == !wr_bank));
`else
  assign other_free = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= W_FILL;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    s_ready = 1'b0;
    case (state)
      W_FILL: begin
        s_ready = !rst;
        if (complete && !other_free) state_n = W_WAIT;
      end
      W_WAIT: begin
        if (done_acc) state_n = W_FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt  <= '0;
      wr_win  <= '0;
      wr_slot <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept && (s_last != at_last);
      if (accept) begin
        if (at_last) begin
          wr_cnt  <= '0;
          wr_win  <= '0;
          wr_slot <= '0;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
          if (wr_slot == SW'(BPW - 1)) begin
            wr_slot <= '0;
            wr_win  <= wr_win + 1'b1;
          end else begin
            wr_slot <= wr_slot + 1'b1;
          end
        end
      end
      if (done_acc) begin
        full[rd_bank] <= 1'b0;
`ifdef PHASE_ROW_CACHE_PINGPONG_EN
        rd_bank <= !rd_bank;
`endif
      end
      // While waiting, wr_bank already names the bank to refill once it frees.
      if (complete) begin
        full[wr_bank] <= 1'b1;
`ifdef PHASE_ROW_CACHE_PINGPONG_EN
        wr_bank <= !wr_bank;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_bank][wr_win][wr_slot] <= s_data;
  end

  always_comb begin
    win_data = '0;
    if (rd_addr < AW'(NWIN)) begin
      for (int i = 0; i < BPW; i++) begin
        win_data[i*BEAT_W +: BEAT_W] = mem[rd_bank][rd_addr][SW'(i)];
      end
    end
  end

  // The bank is captured with the address, so later bank switches never touch in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= win_data;
      for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

endmodule

// File: tb/tb_phase_row_cache.sv
// tb/tb_phase_row_cache.sv - randomized scoreboard bench for phase_row_cache
// Honours PHASE_ROW_CACHE_PINGPONG_EN the same way as the design.
module tb_phase_row_cache;

  localparam int ROW = 1280, WIN = 128, BEAT = 8, DW = 16, L = 2;
  localparam int NWIN = ROW / WIN, BPR = ROW / BEAT;
`ifdef PHASE_ROW_CACHE_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [BEAT*DW-1:0]  s_data;
  logic                s_valid, s_ready, s_last;
  logic [3:0]          rd_addr;
  logic [WIN*DW-1:0]   rd_data;
  logic                row_vld, row_done, err_len;

  always #5 clk = ~clk;

  phase_row_cache #(.ROW_SIZE(ROW), .WIN_SIZE(WIN), .BEAT_SIZE(BEAT),
                    .DATA_WIDTH(DW), .READ_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .rd_addr(rd_addr), .rd_data(rd_data), .row_vld(row_vld),
    .row_done(row_done), .err_len(err_len));

  typedef struct {
    logic [WIN*DW-1:0] data;
    int                due;
    bit                chk;
    int                addr;
  } rd_t;
  rd_t q[$];

  int tests = 0, fails = 0, cyc = 0;

  // Reference: each bank is a flat row of samples; rows move between banks by the documented rules.
  logic [DW-1:0] mem   [NB][ROW];
  bit            known [NB][ROW];
  bit            m_full[NB];
  int            m_wr, m_rd, m_cnt, gbeat;
  bit            m_wait, m_err, rd_en, flip;

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0b exp=%0b", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_cnt = 0; m_wait = 0; m_err = 0;
    for (int b = 0; b < NB; b++) m_full[b] = 0;
  endtask

  task automatic drive(input bit v);
    s_valid = v;
    for (int k = 0; k < BEAT; k++) s_data[k*DW +: DW] = DW'(gbeat * BEAT + k);
    s_last = (m_cnt == BPR - 1) ^ flip;
  endtask

  task automatic step();
    bit acc, dacc, kn;
    logic [WIN*DW-1:0] w;
    rd_t e;
    @(negedge clk);
    chk("s_ready", s_ready, !rst && !m_wait);
    chk("row_vld", row_vld, !rst && m_full[m_rd]);
    chk("err_len", err_len, !rst && m_err);
    if (rst) chk("rd_data_rst_zero", rd_data == '0, 1'b1);
    @(posedge clk);
    if (rst) begin
      model_reset();
      q.delete();
    end else begin
      acc  = s_valid && !m_wait;
      dacc = row_done && m_full[m_rd];
      if (rd_en) begin
        w = '0; kn = 1;
        if (int'(rd_addr) < NWIN)
          for (int i = 0; i < WIN; i++) begin
            w[i*DW +: DW] = mem[m_rd][int'(rd_addr)*WIN + i];
            kn = kn && known[m_rd][int'(rd_addr)*WIN + i];
          end
        e.data = w; e.due = cyc + L; e.chk = kn; e.addr = int'(rd_addr);
        q.push_back(e);
      end
      m_err = acc && (s_last != (m_cnt == BPR - 1));
      if (acc) begin
        for (int k = 0; k < BEAT; k++) begin
          mem[m_wr][m_cnt*BEAT + k]   = DW'(gbeat * BEAT + k);
          known[m_wr][m_cnt*BEAT + k] = 1;
        end
        gbeat++;
      end
      if (dacc) begin
        m_full[m_rd] = 0;
        if (NB == 2) m_rd = 1 - m_rd;
        m_wait = 0;
      end
      if (acc && m_cnt == BPR - 1) begin
        m_full[m_wr] = 1;
        m_cnt = 0;
        if (NB == 2) begin
          m_wr = 1 - m_wr;
          if (m_full[m_wr]) m_wait = 1;
        end else begin
          m_wait = 1;
        end
      end else if (acc) begin
        m_cnt++;
      end
    end
    cyc++;
    #1;
  endtask

  always @(negedge clk) begin
    rd_t e;
    while (q.size() > 0 && q[0].due < cyc) begin
      e = q.pop_front();
      tests++; fails++;
      $display("FAIL rd_data_missed addr=%0d due=%0d", e.addr, e.due);
    end
    while (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      if (e.chk) begin
        tests++;
        if (rd_data !== e.data) begin
          int idx;
          idx = 0;
          for (int i = WIN - 1; i >= 0; i--)
            if (rd_data[i*DW +: DW] !== e.data[i*DW +: DW]) idx = i;
          fails++;
          $display("FAIL rd_data addr=%0d sample=%0d got=%0d exp=%0d", e.addr, idx,
                   rd_data[idx*DW +: DW], e.data[idx*DW +: DW]);
        end
      end
    end
  end

  task automatic stream_row(input int flip_at);
    for (int b = 0; b < 400 && !(b >= BPR && !m_wait && m_cnt == 0); b++) begin
      flip = (m_cnt == flip_at);
      drive(1);
      step();
      if (b >= BPR - 1 && m_cnt == 0 && !m_wait) break;
    end
    flip = 0;
    drive(0);
  endtask

  task automatic read_all();
    rd_en = 1;
    for (int a = 0; a < 12; a++) begin
      rd_addr = 4'(a);
      step();
    end
    rd_en = 0;
    repeat (L + 1) step();
  endtask

  initial begin
    rst = 1; s_valid = 0; s_last = 0; s_data = '0; row_done = 0; rd_addr = '0;
    rd_en = 0; flip = 0; gbeat = 0;
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < ROW; i++) begin mem[b][i] = '0; known[b][i] = 0; end
    model_reset();
    repeat (3) step();
    rst = 0;
    row_done = 1; step(); row_done = 0;
    stream_row(-1);
    step();
    rd_en = 1;
    rd_addr = 4'd3;  step();
    rd_addr = 4'd0;  step();
    rd_addr = 4'd9;  step();
    rd_addr = 4'd10; step();
    rd_en = 0;
    repeat (L + 1) step();
    row_done = 1; step(); row_done = 0;
    stream_row(100);
    stream_row(-1);
    repeat (4) step();
    read_all();
    row_done = 1; step(); row_done = 0;
    repeat (2) step();
    read_all();
    for (int c = 0; c < 2500; c++) begin
      flip     = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 3) != 0);
      row_done = ($urandom_range(0, 15) == 0);
      rd_en    = ($urandom_range(0, 1) == 1);
      rd_addr  = 4'($urandom_range(0, 15));
      step();
    end
    flip = 0; row_done = 0; rd_en = 0; drive(0);
    repeat (L + 1) step();
    for (int c = 0; c < 600 && (m_wait || m_cnt != 51); c++) begin
      row_done = m_full[m_rd];
      drive(!m_wait && m_cnt != 51);
      step();
    end
    row_done = 0; drive(0);
    rst = 1; q.delete();
    repeat (2) step();
    rst = 0;
    stream_row(-1);
    step();
    read_all();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
